inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 26 ++
 rtl/inst_field_pack.sv | 30 +++
 rtl/inst_encoder.sv | 98 +++++++++
 tb/tb_inst_encoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Opcodes, request kind codes and FSM state encoding shared by the
// instruction encoder and the control decoder.
package inst_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [2:0] KIND_R     = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_J     = 3'd4;
  localparam logic [2:0] KIND_ADDIU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packing of request kind and fields into a 32-bit MIPS word.
module inst_field_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_R:     word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      KIND_ADDIU: word = {OP_ADDIU, rs, rt, imm};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Accepts encode requests and writes the packed words sequentially into
// instruction memory, pulsing done at batch end and latching FULL at 1023.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  input  logic        req_last,
  output logic        im_wen,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        done,
  output logic        err
);

  state_t      state;
  logic [9:0]  ptr;
  logic        last_q;
  logic [31:0] word;
  logic        illegal;
  logic        hs;

  inst_field_pack u_pack (
    .kind    (req_kind),
    .funct   (req_funct),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .target  (req_target),
    .word    (word),
    .illegal (illegal)
  );

  always_comb begin
    req_ready = (state == ST_IDLE);
    im_wen    = (state == ST_WRITE);
    done      = (state == ST_DONE);
    im_addr   = ptr;
    hs        = req_valid && req_ready;
  end

  // The packed word is registered in place of the raw fields; im_wdata only
  // changes on entry to WRITE, so it holds whenever im_wen is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      last_q   <= 1'b0;
      im_wdata <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            last_q <= req_last;
            if (illegal) begin
              err   <= 1'b1;
              state <= req_last ? ST_DONE : ST_IDLE;
            end else begin
              im_wdata <= word;
              state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (last_q || ptr == '1) begin
            state <= ST_DONE;
          end else begin
            ptr   <= ptr + 10'd1;
            state <= ST_IDLE;
          end
        end
        // DONE without a pending last can only follow a write at 1023.
        ST_DONE: begin
          if (!last_q) begin
            state <= ST_FULL;
          end else begin
            ptr   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_FULL: state <= ST_FULL;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder against a word-level reference model.
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [5:0]  req_funct;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        req_last;
  logic        im_wen;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;
  int unsigned exp_ptr;
  logic [31:0] exp_wdata;
  logic        exp_err;

  inst_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_funct  (req_funct),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_imm    (req_imm),
    .req_target (req_target),
    .req_last   (req_last),
    .im_wen     (im_wen),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input int unsigned kind, funct, rs, rt, rd, imm, target);
    int unsigned op;
    case (kind)
      0: return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + funct);
      1: op = 35;
      2: op = 43;
      3: op = 4;
      4: return 32'(2 * 67108864 + target);
      5: op = 9;
      default: return 32'd0;
    endcase
    return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req_kind   = 3'($urandom_range(0, 7));
    req_funct  = 6'($urandom);
    req_rs     = 5'($urandom);
    req_rt     = 5'($urandom);
    req_rd     = 5'($urandom);
    req_imm    = 16'($urandom);
    req_target = 26'($urandom);
    req_last   = 1'($urandom);
  endtask

  task automatic set_req(input int unsigned kind, funct, rs, rt, rd, imm, target, input bit last);
    req_kind   = 3'(kind);
    req_funct  = 6'(funct);
    req_rs     = 5'(rs);
    req_rt     = 5'(rt);
    req_rd     = 5'(rd);
    req_imm    = 16'(imm);
    req_target = 26'(target);
    req_last   = last;
    req_valid  = 1'b1;
  endtask

  task automatic apply_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ptr = 0;
    exp_wdata = '0;
    exp_err = 1'b0;
  endtask

  // One request from IDLE through its write and any done pulse; garbage keeps
  // an illegal request valid while the block is busy, which must be ignored.
  task automatic do_txn(input int unsigned kind, funct, rs, rt, rd, imm, target,
                        input bit last, input bit garbage, output logic [31:0] seen);
    logic [31:0] exp_w;
    bit legal;
    legal = (kind < 6);
    exp_w = ref_word(kind, funct, rs, rt, rd, imm, target);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle: got %b expected 1", req_ready); end
    set_req(kind, funct, rs, rt, rd, imm, target, last);
    tick();
    seen = im_wdata;
    if (garbage && legal) begin
      scramble();
      req_kind = 3'd7;
    end else begin
      req_valid = 1'b0;
    end
    if (legal) begin
      exp_wdata = exp_w;
      n_checks++; if (im_wen !== 1'b1) begin n_fail++; $display("FAIL wen_write: got %b expected 1", im_wen); end
      n_checks++; if (im_addr !== 10'(exp_ptr)) begin n_fail++; $display("FAIL addr_write: got %h expected %h", im_addr, 10'(exp_ptr)); end
      n_checks++; if (im_wdata !== exp_w) begin n_fail++; $display("FAIL wdata: kind %0d got %h expected %h", kind, im_wdata, exp_w); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_write: got %b expected 0", req_ready); end
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL err_write: got %b expected %b", err, exp_err); end
      tick();
      req_valid = 1'b0;
      if (last || exp_ptr == 1023) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", done); end
        n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL wen_done: got %b expected 0", im_wen); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_done: got %b expected 0", req_ready); end
        n_checks++; if (im_wdata !== exp_wdata) begin n_fail++; $display("FAIL wdata_hold_done: got %h expected %h", im_wdata, exp_wdata); end
        if (last) begin
          tick();
          exp_ptr = 0;
          n_checks++; if (im_addr !== 10'd0) begin n_fail++; $display("FAIL ptr_clear: got %h expected 000", im_addr); end
          n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
          n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done: got %b expected 1", req_ready); end
        end
      end else begin
        exp_ptr++;
        n_checks++; if (im_addr !== 10'(exp_ptr)) begin n_fail++; $display("FAIL ptr_inc: got %h expected %h", im_addr, 10'(exp_ptr)); end
        n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL wen_idle: got %b expected 0", im_wen); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_idle: got %b expected 0", done); end
        n_checks++; if (im_wdata !== exp_wdata) begin n_fail++; $display("FAIL wdata_hold: got %h expected %h", im_wdata, exp_wdata); end
      end
    end else begin
      exp_err = 1'b1;
      n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL wen_illegal: got %b expected 0", im_wen); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
      n_checks++; if (im_addr !== 10'(exp_ptr)) begin n_fail++; $display("FAIL addr_illegal: got %h expected %h", im_addr, 10'(exp_ptr)); end
      n_checks++; if (im_wdata !== exp_wdata) begin n_fail++; $display("FAIL wdata_illegal: got %h expected %h", im_wdata, exp_wdata); end
      if (last) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_illegal: got %b expected 1", done); end
        tick();
        exp_ptr = 0;
        n_checks++; if (im_addr !== 10'd0) begin n_fail++; $display("FAIL ptr_clear_illegal: got %h expected 000", im_addr); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle_illegal: got %b expected 0", done); end
      end else begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_illegal_nolast: got %b expected 0", done); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_illegal: got %b expected 1", req_ready); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(5, 0, 0, 8, 0, 5, 0, 0);
    tick();
    tick();
    n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b expected 0", im_wen); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_checks++; if (im_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr: got %h expected 000", im_addr); end
    n_checks++; if (im_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 00000000", im_wdata); end
    req_valid = 1'b0;
    rst = 1'b0;
    exp_ptr = 0;
    exp_wdata = '0;
    exp_err = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    tick();
    n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL rst_no_write: got %b expected 0", im_wen); end
  endtask

  task automatic test_directed();
    logic [31:0] seen;
    do_txn(5, 0, 0, 8, 0, 16'h0005, 0, 0, 0, seen);
    n_checks++; if (seen !== 32'h24080005) begin n_fail++; $display("FAIL addiu_word: got %h expected 24080005", seen); end
    do_txn(0, 6'h21, 9, 10, 8, 0, 0, 0, 0, seen);
    n_checks++; if (seen !== 32'h012A4021) begin n_fail++; $display("FAIL rtype_word: got %h expected 012a4021", seen); end
    do_txn(1, 0, 29, 8, 0, 4, 0, 0, 0, seen);
    n_checks++; if (seen !== 32'h8FA80004) begin n_fail++; $display("FAIL lw_word: got %h expected 8fa80004", seen); end
    do_txn(2, 0, 29, 8, 0, 4, 0, 0, 0, seen);
    n_checks++; if (seen !== 32'hAFA80004) begin n_fail++; $display("FAIL sw_word: got %h expected afa80004", seen); end
    do_txn(3, 0, 8, 9, 0, 16'hFFFF, 0, 0, 0, seen);
    n_checks++; if (seen !== 32'h1109FFFF) begin n_fail++; $display("FAIL beq_word: got %h expected 1109ffff", seen); end
    do_txn(4, 0, 0, 0, 0, 0, 26'h0000010, 1, 0, seen);
    n_checks++; if (seen !== 32'h08000010) begin n_fail++; $display("FAIL j_word: got %h expected 08000010", seen); end
    do_txn(5, 0, 1, 2, 0, 3, 0, 0, 0, seen);
    do_txn(6, 0, 0, 0, 0, 0, 0, 1, 0, seen);
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_random();
    logic [31:0] seen;
    int unsigned kind;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      kind = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 7);
      do_txn(kind, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863),
             $urandom_range(0, 5) == 0, 1'($urandom), seen);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        req_valid = 1'b0;
        scramble();
        tick();
        n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL wen_no_handshake: got %b expected 0", im_wen); end
        n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL err_model: got %b expected %b", err, exp_err); end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] seen;
    apply_reset();
    for (int i = 0; i < 1024; i++)
      do_txn(5, 0, i % 32, (i + 3) % 32, 0, i, 0, 0, i % 2, seen);
    n_checks++; if (im_addr !== 10'h3FF) begin n_fail++; $display("FAIL full_last_addr: got %h expected 3ff", im_addr); end
    tick();
    for (int c = 0; c < 6; c++) begin
      set_req(5, 0, 1, 1, 0, 7, 0, 0);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", req_ready); end
      n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL full_wen: got %b expected 0", im_wen); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done: got %b expected 0", done); end
      tick();
    end
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_exit_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_rst_mid_write();
    logic [31:0] seen;
    apply_reset();
    do_txn(7, 0, 0, 0, 0, 0, 0, 0, 0, seen);
    do_txn(5, 0, 1, 2, 0, 10, 0, 0, 0, seen);
    do_txn(5, 0, 1, 2, 0, 11, 0, 0, 0, seen);
    set_req(5, 0, 1, 2, 0, 12, 0, 0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (im_wen !== 1'b1 || im_addr !== 10'd2) begin n_fail++; $display("FAIL word3_write: got wen %b addr %h expected 1 002", im_wen, im_addr); end
    rst = 1'b1;
    tick();
    n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_wen: got %b expected 0", im_wen); end
    n_checks++; if (im_addr !== 10'd0) begin n_fail++; $display("FAIL rst_cancel_ptr: got %h expected 000", im_addr); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_err: got %b expected 0", err); end
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cancel_ready: got %b expected 1", req_ready); end
    tick();
    n_checks++; if (im_wen !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_nowrite: got %b expected 0", im_wen); end
  endtask

  task automatic test_rst_in_done();
    apply_reset();
    set_req(1, 0, 3, 4, 0, 8, 0, 1);
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_before_rst: got %b expected 1", done); end
    rst = 1'b1;
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_cancel_done: got %b expected 0", done); end
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done_rst: got %b expected 1", req_ready); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    scramble();
    test_reset();
    test_directed();
    test_random();
    test_full();
    test_rst_mid_write();
    test_rst_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
